// File: rtl/serial_adder_nb_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and counter sizing.
package serial_adder_nb_pkg;

    // Binary state encoding for the sequencer.
    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_FIN  = 2'd2
    } sa_state_t;

    // Bit counter width. A one-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_nb_fa_1b.sv
// One-bit full adder cell: the per-bit arithmetic of the serial adder.
module fa_1b (
    input  logic in0,
    input  logic in1,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    // Sum is the three-input parity; carry is the majority of the three inputs.
    always_comb begin
        sum       = in0 ^ in1 ^ carry_in;
        carry_out = (in0 & in1) | (in0 & carry_in) | (in1 & carry_in);
    end

endmodule

// File: rtl/serial_adder_nb.sv
// Bit-serial WIDTH-bit adder. One bit per clock, LSB first, through a single
// full-adder cell and a registered carry. START/BUSY/DONE handshake; the result
// registers only change at the completing edge.
module serial_adder_nb
    import serial_adder_nb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = cnt_width(WIDTH);

    sa_state_t        state_reg;
    sa_state_t        state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             c_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_out_reg;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] r_shift;
    logic             last_bit;
    logic             load;
    logic             step;

    // The single adder cell always looks at the current LSBs and the carry.
    fa_1b u_fa (
        .in0       (a_reg[0]),
        .in1       (b_reg[0]),
        .carry_in  (c_reg),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    // Result shift: the new sum bit enters at the MSB, so after WIDTH steps
    // the first (LSB) sum bit has walked down to bit 0.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_rshift
            assign r_shift[gi] = r_reg[gi + 1];
        end
    endgenerate
    assign r_shift[WIDTH-1] = fa_sum;

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SA_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath control. FIN accepts START just like IDLE so
    // back-to-back operations lose no cycle beyond the DONE cycle.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            SA_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SA_RUN;
                end
            end
            SA_RUN: begin
                step = 1'b1;
                if (last_bit) begin
                    state_next = SA_FIN;
                end
            end
            SA_FIN: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SA_RUN;
                end else begin
                    state_next = SA_IDLE;
                end
            end
            default: begin
                state_next = SA_IDLE;
            end
        endcase
    end

    // Operand shifters, carry, bit counter and the held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= 1'b0;
            cnt_reg       <= '0;
            r_reg         <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else if (load) begin
            a_reg   <= in0;
            b_reg   <= in1;
            c_reg   <= carry_in;
            cnt_reg <= '0;
            r_reg   <= '0;
        end else if (step) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            c_reg <= fa_carry;
            r_reg <= r_shift;
            if (last_bit) begin
                sum_reg       <= r_shift;
                carry_out_reg <= fa_carry;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign busy      = (state_reg == SA_RUN);
    assign done      = (state_reg == SA_FIN);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_serial_adder_nb.sv
// Scoreboard bench for serial_adder_nb: an 8-bit instance with directed vectors
// and a 1-bit instance checked against a+b+cin.
module tb_serial_adder_nb;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         dcyc;
    } exp8_t;

    typedef struct {
        logic       sum;
        logic       cout;
        int         dcyc;
    } exp1_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    logic       start8 = 1'b0;
    logic [7:0] in0_8 = '0;
    logic [7:0] in1_8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] in0_1 = '0;
    logic [0:0] in1_1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    exp8_t      q8[$];
    exp1_t      q1[$];
    exp8_t      e8;
    exp1_t      e1;
    logic [7:0] held8 = '0;
    logic       heldc8 = 1'b0;
    int         brun8 = 0;
    int         brun1 = 0;

    serial_adder_nb #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start8),
        .in0       (in0_8),
        .in1       (in1_8),
        .carry_in  (cin8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (cout8)
    );

    serial_adder_nb #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .in0       (in0_1),
        .in1       (in1_1),
        .carry_in  (cin1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit instance: pops on DONE, otherwise checks the result holds.
    always @(negedge clk) begin
        if (!rst_n) begin
            held8  = '0;
            heldc8 = 1'b0;
            brun8  = 0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 32'(done8), 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(e8.sum));
                chk("cout8", 32'(cout8), 32'(e8.cout));
                chk("done8_cycle", 32'(cyc), 32'(e8.dcyc));
                chk("busy8_len", 32'(brun8), 32'd8);
                chk("busy8_in_fin", 32'(busy8), 32'd0);
                held8  = e8.sum;
                heldc8 = e8.cout;
                $display("W8 done: sum=%02h cout=%0d at cycle %0d", sum8, cout8, cyc);
            end
            brun8 = 0;
        end else begin
            chk("sum8_hold", 32'(sum8), 32'(held8));
            chk("cout8_hold", 32'(cout8), 32'(heldc8));
            brun8 = busy8 ? brun8 + 1 : 0;
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            brun1 = 0;
        end else if (done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 32'(done1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("sum1", 32'(sum1), 32'(e1.sum));
                chk("cout1", 32'(cout1), 32'(e1.cout));
                chk("done1_cycle", 32'(cyc), 32'(e1.dcyc));
                chk("busy1_len", 32'(brun1), 32'd1);
                $display("W1 done: sum=%0d cout=%0d at cycle %0d", sum1, cout1, cyc);
            end
            brun1 = 0;
        end else begin
            brun1 = busy1 ? brun1 + 1 : 0;
        end
    end

    // Call at a negedge: present START for one edge, record the expected result.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec);
        exp8_t e;
        in0_8  = a;
        in1_8  = b;
        cin8   = cin;
        start8 = 1'b1;
        e.sum  = es;
        e.cout = ec;
        e.dcyc = cyc + 9;
        q8.push_back(e);
        $display("W8 issue: %02h + %02h + %0d at cycle %0d", a, b, cin, cyc);
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    task automatic issue1(input logic a, input logic b, input logic cin);
        exp1_t      e;
        logic [1:0] t;
        t = 2'(a) + 2'(b) + 2'(cin);
        in0_1  = a;
        in1_1  = b;
        cin1   = cin;
        start1 = 1'b1;
        e.sum  = t[0];
        e.cout = t[1];
        e.dcyc = cyc + 2;
        q1.push_back(e);
        $display("W1 issue: %0d + %0d + %0d at cycle %0d", a, b, cin, cyc);
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    // Leaves the caller at the negedge where DONE is high (FIN cycle).
    task automatic wait_done8();
        int n = 0;
        @(negedge clk);
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) chk("timeout_done8", 32'(done8), 32'd1);
    endtask

    task automatic wait_done1();
        int n = 0;
        @(negedge clk);
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done1) chk("timeout_done1", 32'(done1), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'd0);
        chk("rst_cout8", 32'(cout8), 32'd0);
        chk("rst_sum1", 32'(sum1), 32'd0);
        #1 rst_n = 1'b1;

        // Basic additions and carry boundaries.
        @(negedge clk); issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0); wait_done8();
        @(negedge clk); issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1); wait_done8();
        @(negedge clk); issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1); wait_done8();
        @(negedge clk); issue8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1); wait_done8();

        // START held high through RUN with changing operands must be ignored.
        @(negedge clk); issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        start8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in0_8 = 8'($urandom);
            in1_8 = 8'($urandom);
            cin8  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        start8 = 1'b0;
        wait_done8();

        // Back-to-back: START during the FIN cycle is accepted.
        @(negedge clk); issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1); wait_done8();
        issue8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0); wait_done8();

        // Reset in the middle of RUN: outputs clear at once, no DONE.
        @(negedge clk); issue8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy8", 32'(busy8), 32'd0);
        chk("abort_done8", 32'(done8), 32'd0);
        chk("abort_sum8", 32'(sum8), 32'd0);
        chk("abort_cout8", 32'(cout8), 32'd0);
        void'(q8.pop_back());
        $display("W8 abort: reset asserted mid-RUN at cycle %0d", cyc);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        @(negedge clk); issue8(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0); wait_done8();

        // One-bit instance: directed 1+1+1 then every combination plus random.
        @(negedge clk); issue1(1'b1, 1'b1, 1'b1); wait_done1();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); issue1(i[2], i[1], i[0]); wait_done1();
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); issue1(1'($urandom), 1'($urandom), 1'($urandom)); wait_done1();
        end

        repeat (4) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
